// File: rtl/pc_gen_pkg.sv
// Core-wide fetch definitions: PC generator states and default geometry.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_t;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_STEP      = 4;

endpackage

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised trap/jump redirects, pipeline hold and
// a valid/ready fetch handshake that never alters an outstanding request address.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter int unsigned       STEP      = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              hold_i,
    input  logic              fetch_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetch_valid_o,
    output logic              redirect_o
);

    localparam logic [ADDR_W-1:0] StepW     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] AlignMask = ~(StepW - ADDR_W'(1));

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              redirect_q, redirect_d;

    logic              fire;
    logic              stuck;
    logic              redir;
    logic [ADDR_W-1:0] tgt;

    always_comb begin
        fetch_valid_o = (state_q != BOOT) && !hold_i;
        fire          = fetch_valid_o && fetch_ready_i;
        stuck         = fetch_valid_o && !fetch_ready_i;
        redir         = trap_en_i || jump_en_i;
        tgt           = (trap_en_i ? trap_addr_i : jump_addr_i) & AlignMask;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        redirect_d  = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redir) begin
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                end
            end
            RUN: begin
                if (redir && !stuck) begin
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                end else if (redir) begin
                    // Request outstanding: park the target until it is accepted or dropped.
                    pend_addr_d = tgt;
                    state_d     = PEND;
                end else if (fire) begin
                    pc_d = pc_q + StepW;
                end
            end
            PEND: begin
                if (redir) begin
                    pend_addr_d = tgt;
                end
                if (!stuck) begin
                    pc_d       = redir ? tgt : pend_addr_q;
                    redirect_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            pend_addr_q <= '0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            redirect_q  <= redirect_d;
        end
    end

    assign pc_o       = pc_q;
    assign redirect_o = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor pops and compares.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        redir;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        trap_en = 1'b0;
    logic [31:0] trap_addr = '0;
    logic        hold = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] pc;
    logic        valid;
    logic        redirect;

    logic        rst8 = 1'b1;
    logic [7:0]  pc8;
    logic        valid8;
    logic        redirect8;

    exp_t q32[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idx32 = 0;
    int   idx8 = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .trap_en_i    (trap_en),
        .trap_addr_i  (trap_addr),
        .hold_i       (hold),
        .fetch_ready_i(ready),
        .pc_o         (pc),
        .fetch_valid_o(valid),
        .redirect_o   (redirect)
    );

    pc_gen #(
        .ADDR_W   (8),
        .RESET_VEC(8'hF8),
        .STEP     (4)
    ) dut8 (
        .clk          (clk),
        .rst          (rst8),
        .jump_en_i    (1'b0),
        .jump_addr_i  (8'h00),
        .trap_en_i    (1'b0),
        .trap_addr_i  (8'h00),
        .hold_i       (1'b0),
        .fetch_ready_i(1'b1),
        .pc_o         (pc8),
        .fetch_valid_o(valid8),
        .redirect_o   (redirect8)
    );

    task automatic check(input string what, input int i, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d] actual %h required %h", what, i, act, req);
        end
    endtask

    // Monitor: compares whatever the stimulus side has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                check("pc", e.idx, pc, e.pc);
                check("fetch_valid", e.idx, {31'b0, valid}, {31'b0, e.valid});
                check("redirect", e.idx, {31'b0, redirect}, {31'b0, e.redir});
            end
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("pc8", e.idx, {24'b0, pc8}, e.pc);
                check("fetch_valid8", e.idx, {31'b0, valid8}, {31'b0, e.valid});
                check("redirect8", e.idx, {31'b0, redirect8}, {31'b0, e.redir});
            end
        end
    end

    // Drive one cycle of inputs at posedge+1 and queue the outputs expected during it.
    task automatic step(input logic r, input logic rdy, input logic h,
                        input logic j, input logic [31:0] ja,
                        input logic t, input logic [31:0] ta,
                        input logic [31:0] epc, input logic ev, input logic erd);
        exp_t e;
        rst       = r;
        ready     = rdy;
        hold      = h;
        jump_en   = j;
        jump_addr = ja;
        trap_en   = t;
        trap_addr = ta;
        e.pc = epc; e.valid = ev; e.redir = erd; e.idx = idx32++;
        q32.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic [31:0] epc, input logic ev);
        exp_t e;
        rst8 = 1'b0;
        e.pc = epc; e.valid = ev; e.redir = 1'b0; e.idx = idx8++;
        q8.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // 8-bit instance: wrap from the top of the address space.
        step8(32'hF8, 1'b0);
        step8(32'hF8, 1'b1);
        step8(32'hFC, 1'b1);
        step8(32'h00, 1'b1);
        step8(32'h04, 1'b1);

        //   rst   rdy   hold  jmp   jaddr         trap  taddr         pc            v     rd
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,        32'h10,       1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h10,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h14,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h18,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1C,       1'b1, 1'b0);
        // Stall at 0x20: jump buffered, then overwritten by a trap; neither may move pc_o.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300,      1'b0, 32'h0,        32'h20,       1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h20,       1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h40,       1'b1, 1'b1);
        // Trap beats a simultaneous jump.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200,      1'b1, 32'h80,       32'h44,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       1'b1, 1'b1);
        // Misaligned target has its low bits cleared.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h103,      1'b0, 32'h0,        32'h84,       1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1, 1'b1);
        // Buffered redirect released by hold dropping fetch_valid.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h500,      1'b0, 32'h0,        32'h104,      1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h500,      1'b1, 1'b1);
        // Enter PEND again, then reset asynchronously mid-cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h600,      1'b0, 32'h0,        32'h504,      1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0);
        // Unstalled jump from 0x8 lands in one cycle, then sequential fetch resumes.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h8,        1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1, 1'b0);

        for (int k = 0; k < 10 && (q32.size() != 0 || q8.size() != 0); k++) begin
            @(posedge clk);
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain actual %0d pending required 0", q32.size() + q8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
